tsip_packet_tx: RTL
===================

// Module: tsip_packet_tx
// PURPOSE
//  TSIP command framer for the link to the Thunderbolt GPS (our transmit side; receive side decodes timing packets).
//  On i_start: reads ID + payload from a sync-read buffer, emits DLE,ID,payload(DLE-stuffed),DLE,ETX.
//  Emits bytes over valid/ready to the UART transmitter that drives o_tx_thunder.
// PARAMETERS
//  LEN_W  5  width of payload length and buffer address; max payload = 2**LEN_W-1 bytes
// PORTS
//  i_clk       in   1      system clock
//  i_rst       in   1      asynchronous, active-low reset
//  i_start     in   1      1-cycle request to send a packet; sampled only in IDLE
//  i_id        in   8      TSIP packet ID, captured on accepted i_start
//  i_len       in   LEN_W  payload byte count, captured on accepted i_start (0 legal)
//  o_pl_addr   out  LEN_W  payload buffer read address
//  o_pl_rd     out  1      payload buffer read strobe
//  i_pl_data   in   8      payload byte, valid exactly 1 cycle after o_pl_rd
//  o_tx_data   out  8      byte to UART tx
//  o_tx_dv     out  1      o_tx_data valid
//  i_tx_ready  in   1      UART tx accepts byte when o_tx_dv & i_tx_ready
//  o_busy      out  1      high from accepted start until DONE
//  o_done      out  1      1-cycle pulse after ETX accepted
//  o_err       out  1      1-cycle pulse: start rejected (i_id == 8'h10 or 8'h03)
// BEHAVIOUR
//  Reset (i_rst=0, async): state IDLE; all outputs 0; captured id/len/count cleared.
//  Constants: DLE = 8'h10, ETX = 8'h03.
//  Transfer: byte moves on cycle where o_tx_dv & i_tx_ready; o_tx_data stable while o_tx_dv & !i_tx_ready.
//  FSM (registered outputs):
//   IDLE : i_start & id legal -> SOF, o_busy=1, cnt=0. i_start & id illegal -> o_err pulse, stay IDLE.
//   SOF  : o_tx_dv=1, data=DLE; on transfer -> ID.
//   ID   : data=id; on transfer -> (len==0 ? EDLE : FETCH).
//   FETCH: o_pl_rd=1, o_pl_addr=cnt for 1 cycle, o_tx_dv=0 -> WAIT.
//   WAIT : latch i_pl_data into byte reg -> DATA.
//   DATA : data=byte; on transfer: byte==DLE -> STUFF; else cnt+1, (cnt+1==len ? EDLE : FETCH).
//   STUFF: data=DLE (second copy); on transfer cnt+1, (cnt+1==len ? EDLE : FETCH).
//   EDLE : data=DLE; on transfer -> ETX.
//   ETX  : data=ETX; on transfer -> IDLE, o_done pulse next cycle, o_busy falls same cycle as o_done.
//  Only payload DLE bytes are stuffed; ETX (8'h03) in payload is sent unstuffed.
//  i_start while o_busy: ignored, no error, no queuing. Simultaneous o_done and new i_start: start ignored
//   (o_busy still high); a start is accepted no earlier than the cycle after o_done.
//  o_tx_dv never deasserts without a transfer except on reset.
//  Count arithmetic LEN_W bits; len = 2**LEN_W-1 reads addresses 0..len-1, no wrap.
//  Reset mid-packet: frame abandoned immediately, o_tx_dv drops, no o_done; UART side must flush.
//  Minimum latency start->first o_tx_dv: 1 cycle. Per payload byte: >= 3 cycles (FETCH,WAIT,DATA).
// TESTING
//  1 id=8'h8E, len=0, ready tied 1 -> bytes 10 8E 10 03, o_done once, no o_pl_rd.
//  2 id=8'h8E, len=3, buffer {A5,10,3C} -> 10 8E A5 10 10 3C 10 03; 3 reads at addr 0,1,2.
//  3 Test 2 with random i_tx_ready stalls -> identical byte stream, o_tx_data stable during every stall.
//  4 i_start id=8'h10, then id=8'h03 -> o_err pulse each, o_tx_dv stays 0, o_busy 0.
//  5 i_start mid-packet and on o_done cycle -> ignored; next start after o_done -> full new frame.
//  6 Assert i_rst low during payload of len=31 all-8'h10 -> all outputs 0 at once; restart sends 66-byte frame.

Source files
------------

// File: rtl/tsip_packet_tx_if.sv
// Byte stream from the TSIP framer to the UART transmitter feeding the Thunderbolt link.
// A byte moves on every cycle where o_tx_dv and i_tx_ready are both high.
interface tsip_packet_tx_if;
  logic [7:0] o_tx_data;
  logic       o_tx_dv;
  logic       i_tx_ready;

  modport master (output o_tx_data, output o_tx_dv, input i_tx_ready);
  modport slave  (input o_tx_data, input o_tx_dv, output i_tx_ready);
endinterface

// File: rtl/tsip_packet_tx.sv
// TSIP command framer: DLE, ID, DLE-stuffed payload read from a sync-read buffer, DLE, ETX.
// Every output is a register that is loaded from the next-state decode.
module tsip_packet_tx #(
  parameter int LEN_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [7:0]       i_id,
  input  logic [LEN_W-1:0] i_len,
  output logic [LEN_W-1:0] o_pl_addr,
  output logic             o_pl_rd,
  input  logic [7:0]       i_pl_data,
  tsip_packet_tx_if.master tx,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam logic [7:0] DLE = 8'h10;
  localparam logic [7:0] ETX = 8'h03;

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ID, S_FETCH, S_WAIT, S_DATA, S_STUFF, S_EDLE, S_ETX, S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_id, r_byte, r_tx_data;
  logic [LEN_W-1:0] r_len, r_cnt, r_pl_addr;
  logic             r_tx_dv, r_pl_rd, r_busy, r_done, r_err;

  logic             w_xfer, w_id_legal, w_accept, w_last, w_advance;
  logic [LEN_W-1:0] w_cnt_inc, w_cnt_nxt, w_pl_addr_nxt;
  logic [7:0]       w_tx_data_nxt;
  logic             w_tx_dv_nxt, w_pl_rd_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;

  assign w_xfer     = r_tx_dv & tx.i_tx_ready;
  assign w_id_legal = (i_id != DLE) && (i_id != ETX);
  assign w_accept   = (r_state == S_IDLE) && i_start;
  assign w_cnt_inc  = r_cnt + LEN_W'(1);
  assign w_last     = (w_cnt_inc == r_len);
  // A payload byte is finished once its final copy (the stuffed one for DLE) has gone out.
  assign w_advance  = w_xfer && ((r_state == S_STUFF) || (r_state == S_DATA && r_byte != DLE));
  assign w_cnt_nxt  = (w_accept && w_id_legal) ? '0 : (w_advance ? w_cnt_inc : r_cnt);

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_tx_data <= '0;
      r_tx_dv   <= 1'b0;
      r_pl_rd   <= 1'b0;
      r_pl_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      r_state   <= w_state_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tx_dv   <= w_tx_dv_nxt;
      r_pl_rd   <= w_pl_rd_nxt;
      r_pl_addr <= w_pl_addr_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_id   <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_byte <= '0;
    end else begin
      if (w_accept && w_id_legal) begin
        r_id  <= i_id;
        r_len <= i_len;
      end
      r_cnt <= w_cnt_nxt;
      if (r_state == S_WAIT) r_byte <= i_pl_data;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start && w_id_legal) w_state_nxt = S_SOF;
      S_SOF:   if (w_xfer) w_state_nxt = S_ID;
      S_ID:    if (w_xfer) w_state_nxt = (r_len == '0) ? S_EDLE : S_FETCH;
      S_FETCH: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_DATA;
      S_DATA:  if (w_xfer) w_state_nxt = (r_byte == DLE) ? S_STUFF : (w_last ? S_EDLE : S_FETCH);
      S_STUFF: if (w_xfer) w_state_nxt = w_last ? S_EDLE : S_FETCH;
      S_EDLE:  if (w_xfer) w_state_nxt = S_ETX;
      S_ETX:   if (w_xfer) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state, so outputs line up with the state they describe.
  always_comb begin
    w_tx_data_nxt = '0;
    w_tx_dv_nxt   = 1'b0;
    w_pl_rd_nxt   = 1'b0;
    w_pl_addr_nxt = '0;
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_done_nxt    = (w_state_nxt == S_DONE);
    w_err_nxt     = w_accept && !w_id_legal;
    case (w_state_nxt)
      S_SOF, S_STUFF, S_EDLE: begin
        w_tx_dv_nxt   = 1'b1;
        w_tx_data_nxt = DLE;
      end
      S_ID: begin
        w_tx_dv_nxt   = 1'b1;
        w_tx_data_nxt = r_id;
      end
      S_FETCH: begin
        w_pl_rd_nxt   = 1'b1;
        w_pl_addr_nxt = w_cnt_nxt;
      end
      S_DATA: begin
        w_tx_dv_nxt   = 1'b1;
        w_tx_data_nxt = (r_state == S_WAIT) ? i_pl_data : r_byte;
      end
      S_ETX: begin
        w_tx_dv_nxt   = 1'b1;
        w_tx_data_nxt = ETX;
      end
      default: ;
    endcase
  end

  assign tx.o_tx_data = r_tx_data;
  assign tx.o_tx_dv   = r_tx_dv;
  assign o_pl_rd      = r_pl_rd;
  assign o_pl_addr    = r_pl_addr;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
